// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern generator and its sink.
// Carries PIXELS_PER_BEAT pixels per beat, tuser = SOF, tlast = EOL.
interface axis_video_pattern_gen_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int PIXELS_PER_BEAT = 1
) ();
    logic [DATA_WIDTH*PIXELS_PER_BEAT-1:0] tdata;
    logic                                  tvalid;
    logic                                  tready;
    logic                                  tuser;
    logic                                  tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: full frames with blanking, free-run or one-shot.
// Optional SOF frame stamping in lane 0 enabled by defining AXIS_VIDEO_PATTERN_FRAME_STAMP_EN.
module axis_video_pattern_gen #(
    parameter int DATA_WIDTH      = 8,
    parameter int PIXELS_PER_BEAT = 1,
    parameter int H_PIXELS        = 800,
    parameter int V_LINES         = 600,
    parameter int H_BLANK         = 16,
    parameter int V_BLANK         = 4,
    parameter int CNT_WIDTH       = 12
) (
    input  logic                        m_axis_aclk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        one_shot,
    input  logic                        trigger,
    input  logic [1:0]                  pattern_sel,
    input  logic [DATA_WIDTH-1:0]       solid_color,
    axis_video_pattern_gen_if.master    m_axis,
    output logic                        frame_busy,
    output logic [15:0]                 frame_count
);
    localparam int PPB = PIXELS_PER_BEAT;
    localparam int AW  = CNT_WIDTH + 4;
`ifdef AXIS_VIDEO_PATTERN_FRAME_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_VBLANK = 2'd3;

    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(H_PIXELS - PPB);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(V_LINES - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [15:0]           blank_q, blank_d;
    logic                  pend_q, pend_d;
    logic                  sof_q, sof_d;
    logic [15:0]           fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic [2:0]            bar_q, bar_d, bar_nxt;
    logic [AW-1:0]         bacc_q, bacc_d, bacc_nxt;
    logic [1:0]            pat_q, pat_d;
    logic [DATA_WIDTH-1:0] solid_q, solid_d;
    logic [2:0]            lane_bar [PPB];
    logic [DATA_WIDTH*PPB-1:0] pix_c;
    logic [DATA_WIDTH-1:0] stamp_c;
    logic                  tvalid_c, hs, start;

    function automatic logic [DATA_WIDTH-1:0] pixel_of(
        input logic [1:0]            pat,
        input logic [DATA_WIDTH-1:0] idx,
        input logic [2:0]            bar,
        input logic [DATA_WIDTH-1:0] solid,
        input logic                  chk
    );
        logic [DATA_WIDTH-1:0] px;
        px = '0;
        case (pat)
            2'd0:    px = idx;
            2'd1:    for (int i = 0; i < DATA_WIDTH; i++) px[i] = bar[i % 3];
            2'd2:    px = solid;
            default: px = {DATA_WIDTH{chk}};
        endcase
        return px;
    endfunction

    // Bar index per lane: bacc_q tracks x*8 mod H_PIXELS, each pixel adds 8
    always_comb begin
        logic [AW-1:0] acc;
        logic [2:0]    bar;
        acc = bacc_q;
        bar = bar_q;
        for (int l = 0; l < PPB; l++) begin
            lane_bar[l] = bar;
            acc = acc + AW'(8);
            for (int k = 0; k < 8; k++) begin
                if (acc >= AW'(H_PIXELS)) begin
                    acc = acc - AW'(H_PIXELS);
                    bar = bar + 3'd1;
                end
            end
        end
        bar_nxt  = bar;
        bacc_nxt = acc;
    end

    always_comb begin
        stamp_c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) stamp_c[i] = (i < 16) ? fcnt_q[i % 16] : 1'b0;
    end

    always_comb begin
        pix_c = '0;
        for (int l = 0; l < PPB; l++) begin
            pix_c[l*DATA_WIDTH +: DATA_WIDTH] = pixel_of(pat_q, idx_q + DATA_WIDTH'(l), lane_bar[l], solid_q,
                (|((x_q + CNT_WIDTH'(l)) & CNT_WIDTH'(8))) ^ y_q[3]);
        end
        if (STAMP_EN && sof_q) pix_c[DATA_WIDTH-1:0] = stamp_c;
    end

    assign tvalid_c      = (state_q == ST_ACTIVE);
    assign hs            = tvalid_c & m_axis.tready;
    assign m_axis.tvalid = tvalid_c;
    assign m_axis.tdata  = tvalid_c ? pix_c : '0;
    assign m_axis.tuser  = tvalid_c & sof_q;
    assign m_axis.tlast  = tvalid_c & (x_q == X_LAST);
    assign frame_busy    = (state_q != ST_IDLE);
    assign frame_count   = fcnt_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        pend_d  = pend_q;
        sof_d   = sof_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        bar_d   = bar_q;
        bacc_d  = bacc_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        start   = 1'b0;
        if (one_shot && enable && trigger && state_q != ST_IDLE) pend_d = 1'b1;
        case (state_q)
            ST_IDLE: start = enable && (!one_shot || trigger || pend_q);
            ST_ACTIVE: begin
                if (hs) begin
                    x_d    = x_q + CNT_WIDTH'(PPB);
                    idx_d  = idx_q + DATA_WIDTH'(PPB);
                    bar_d  = bar_nxt;
                    bacc_d = bacc_nxt;
                    sof_d  = 1'b0;
                    if (x_q == X_LAST) begin
                        x_d    = '0;
                        bar_d  = '0;
                        bacc_d = '0;
                        if (y_q == Y_LAST) begin
                            fcnt_d = fcnt_q + 16'd1;
                            if (V_BLANK != 0) begin
                                state_d = ST_VBLANK;
                                blank_d = 16'(V_BLANK - 1);
                            end else if (!one_shot && enable) begin
                                start = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            y_d = y_q + CNT_WIDTH'(1);
                            if (H_BLANK != 0) begin
                                state_d = ST_HBLANK;
                                blank_d = 16'(H_BLANK - 1);
                            end
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == 16'd0) state_d = ST_ACTIVE;
                else                  blank_d = blank_q - 16'd1;
            end
            default: begin
                if (blank_q == 16'd0) begin
                    if (!one_shot && enable) start   = 1'b1;
                    else                     state_d = ST_IDLE;
                end else begin
                    blank_d = blank_q - 16'd1;
                end
            end
        endcase
        // Frame start: clear position, latch pattern controls for the whole frame
        if (start) begin
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            idx_d   = '0;
            bar_d   = '0;
            bacc_d  = '0;
            sof_d   = 1'b1;
            pend_d  = 1'b0;
            pat_d   = pattern_sel;
            solid_d = solid_color;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= '0;
            pend_q  <= 1'b0;
            sof_q   <= 1'b0;
            fcnt_q  <= '0;
            idx_q   <= '0;
            bar_q   <= '0;
            bacc_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            pend_q  <= pend_d;
            sof_q   <= sof_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            bar_q   <= bar_d;
            bacc_q  <= bacc_d;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        pat_q   <= pat_d;
        solid_q <= solid_d;
    end
endmodule

// File: doc/axis_video_pattern_gen.md
Name: axis_video_pattern_gen

Overview:
- Parametrised AXI4-Stream video source. Successor to the fixed-size camera sensor model used to exercise the MT9D111 capture path.
- Generates complete frames: tuser marks start of frame (SOF), tlast marks end of line (EOL).
- Configurable frame size, blanking, pixels per beat and test pattern. Supports free-run and one-shot trigger modes and honours tready backpressure.
- Drives the VDMA and HOG pipeline directly, without a camera, in simulation and on board.

Parameters:
- DATA_WIDTH, 8: bits per pixel.
- PIXELS_PER_BEAT, 1: pixels per stream beat; legal values 1, 2, 4.
- H_PIXELS, 800: active pixels per line; must be a multiple of PIXELS_PER_BEAT.
- V_LINES, 600: active lines per frame.
- H_BLANK, 16: idle cycles after each line except the last; 0 means no gap.
- V_BLANK, 4: idle cycles after the last line of a frame; 0 means no gap.
- CNT_WIDTH, 12: width of the x/y counters; must hold H_PIXELS and V_LINES.

Ports:
- m_axis_aclk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run request.
- one_shot, in, 1: 1 selects one-shot mode; 0 selects free-run.
- trigger, in, 1: single-cycle pulse that starts one frame in one-shot mode.
- pattern_sel, in, 2: 0 = pixel index, 1 = colour bars, 2 = solid, 3 = checkerboard.
- solid_color, in, DATA_WIDTH: pixel value used by pattern 2.
- m_axis_tdata, out, DATA_WIDTH*PIXELS_PER_BEAT: pixel data; pixel x in lane 0 (LSBs), x+1 in lane 1, and so on.
- m_axis_tvalid, out, 1: beat valid.
- m_axis_tready, in, 1: sink ready.
- m_axis_tuser, out, 1: SOF, asserted on the first beat of a frame only.
- m_axis_tlast, out, 1: EOL, asserted on the last beat of each line.
- frame_busy, out, 1: high from frame start to the end of V_BLANK.
- frame_count, out, 16: number of completed frames; wraps.

Behaviour:
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- Reset values: state IDLE; all outputs 0; counters 0; trigger-pending flag 0. A reset mid-frame aborts immediately; tvalid is 0 after that edge.
- Start condition, evaluated in IDLE:
  - free-run: enable=1.
  - one-shot: enable=1 and (trigger=1 or trigger pending).
- IDLE to ACTIVE on the cycle the start condition is sampled. tvalid=1 and tuser=1 in the following cycle (1-cycle latency).
- pattern_sel and solid_color are latched at frame start and held constant for the whole frame.
- ACTIVE:
  - tvalid=1. Outputs and counters change only on a handshake (tvalid & tready). While tready=0, tdata, tuser and tlast hold stable.
  - Each handshake adds PIXELS_PER_BEAT to x.
  - tlast=1 when x + PIXELS_PER_BEAT == H_PIXELS.
- On a tlast handshake:
  - Not the last line: y increments, x returns to 0, go to HBLANK, or stay in ACTIVE if H_BLANK=0.
  - Last line (y == V_LINES-1): frame_count increments, go to VBLANK, or go directly to the next state if V_BLANK=0.
- HBLANK and VBLANK: tvalid=0. They last exactly H_BLANK and V_BLANK cycles, counted regardless of tready.
- End of VBLANK:
  - free-run with enable=1: go to ACTIVE; the next beat carries tuser=1 in the cycle after VBLANK ends.
  - otherwise: go to IDLE.
- enable dropped mid-frame: the current frame completes (no truncated frames); the block then goes to IDLE.
- Trigger in one-shot mode:
  - A trigger while frame_busy=1 sets pending; multiple triggers collapse into one.
  - pending clears on frame start.
  - A trigger with enable=0 is ignored.
- Free-run frame period = (H_PIXELS/PIXELS_PER_BEAT)*V_LINES + H_BLANK*(V_LINES-1) + V_BLANK cycles, with tready held at 1.
- Patterns (x, y = pixel coordinates):
  - 0: pixel = running pixel index y*H_PIXELS + x, mod 2^DATA_WIDTH, kept as an incrementing counter (no multiplier); resets to 0 at each frame start.
  - 1: bar b = x*8/H_PIXELS (0..7), computed from a bar-boundary counter; pixel bit i = b[i mod 3].
  - 2: pixel = latched solid_color.
  - 3: pixel = all ones if x[3]^y[3], else 0 (8x8 squares).
- frame_busy is 0 in IDLE.

Optional Feature:
- Macro: AXIS_VIDEO_PATTERN_FRAME_STAMP_EN.
- Defined: on the SOF beat, lane 0 carries frame_count[DATA_WIDTH-1:0] (zero-extended if DATA_WIDTH > 16) instead of the pattern value. All other lanes and beats are unchanged.
- Undefined: no stamping; the pattern value is output on all beats.

Test Plan:
Bench parameters: DATA_WIDTH=8, PIXELS_PER_BEAT=2, H_PIXELS=8, V_LINES=4, H_BLANK=3, V_BLANK=5.
1. Free-run, pattern 0, tready=1 -> 16 beats per frame; beat 0 tdata=16'h0100 with tuser=1; tlast on beats 3, 7, 11, 15; 3-cycle gaps between lines; frame period 30 cycles; frame_count=1 after the first frame.
2. Same as 1 with random tready (50%) -> beat sequence identical to 1; tdata, tuser and tlast stable while tvalid=1 and tready=0; no beat lost or duplicated.
3. one_shot=1; one trigger -> exactly one frame, then IDLE; a trigger pulse during line 2 -> exactly one further frame after VBLANK; 3 triggers in one frame -> still only one extra frame.
4. Free-run; enable dropped on beat 5 -> frame continues to the tlast on beat 15, then 5 VBLANK cycles, then IDLE; tvalid stays 0 afterwards.
5. reset asserted on beat 6 -> tvalid=0 and frame_count=0 next cycle; after release with enable=1, the first beat has tuser=1 and tdata=16'h0100.
6. pattern_sel=3 -> line 0 beats 0..3 = 16'h0000, 16'h0000, 16'h0000, 16'h0000 (x<8); pattern_sel changed mid-frame -> no effect until the next SOF. With the FRAME_STAMP macro defined, SOF lane 0 of frame 3 = 8'h02.
